// File: rtl/cordic_pkg.sv
// Shared constants and the pipeline tag type for the CORDIC request arbiter.
package cordic_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 16;
   localparam int DEF_NREQ   = 4;

   // Angle scale: pi/4 rad maps to 12868 (16384 per radian).
   localparam logic signed [15:0] PI_4 = 16'sd12868;

   // Id field is wide enough for up to 256 requesters.
   localparam int TAG_ID_W = 8;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: the search starts at rr_ptr and the pointer
// moves just past the winner only when the grant is actually taken.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            take_i,
   output logic            gnt_valid_o,
   output logic [IDW-1:0]  gnt_idx_o
);

   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      int cand;
      cand        = 0;
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NREQ) cand = cand - NREQ;
         if (!gnt_valid_o && req_i[cand[IDW-1:0]]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (take_i) begin
         rr_ptr_d = (gnt_idx_o == IDW'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rr_ptr_q <= '0;
      else          rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one external CORDIC pipeline among NREQ requesters; a tag shift
// register tracks ownership so results are routed back in transfer order.
module cordic_arbiter import cordic_pkg::*; #(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int STAGES = DEF_STAGES,
   parameter  int NREQ   = DEF_NREQ,
   localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CNTW   = $clog2(STAGES + 3)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*WIDTH-1:0] req_x,
   input  logic [NREQ*WIDTH-1:0] req_y,
   input  logic [NREQ*WIDTH-1:0] req_angle,
   input  logic                 drain,
   output logic                 cordic_reset,
   output logic [WIDTH-1:0]     cordic_x_in,
   output logic [WIDTH-1:0]     cordic_y_in,
   output logic [WIDTH-1:0]     cordic_angle_in,
   input  logic [WIDTH-1:0]     cordic_x_out,
   input  logic [WIDTH-1:0]     cordic_y_out,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [WIDTH-1:0]     rsp_x,
   output logic [WIDTH-1:0]     rsp_y,
   output logic                 idle
);

   logic           gnt_valid;
   logic [IDW-1:0] gnt_idx;
   logic           xfer;

   tag_t           tag_q [STAGES+1];
   tag_t           tag_in;

   logic           rsp_valid_q;
   logic [IDW-1:0] rsp_id_q;
   logic [WIDTH-1:0] rsp_x_q, rsp_y_q;
   logic [CNTW-1:0]  in_flight_q, in_flight_d;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_i       (req_valid),
      .take_i      (xfer),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   // Gating with reset_n keeps ready low and idle high throughout reset.
   assign xfer = gnt_valid & ~drain & reset_n;

   always_comb begin
      req_ready = '0;
      if (xfer) req_ready[gnt_idx] = 1'b1;
   end

   assign cordic_reset    = ~reset_n;
   assign cordic_x_in     = xfer ? req_x[int'(gnt_idx)*WIDTH +: WIDTH]     : '0;
   assign cordic_y_in     = xfer ? req_y[int'(gnt_idx)*WIDTH +: WIDTH]     : '0;
   assign cordic_angle_in = xfer ? req_angle[int'(gnt_idx)*WIDTH +: WIDTH] : '0;

   always_comb begin
      tag_in       = '0;
      tag_in.valid = xfer;
      tag_in.id    = TAG_ID_W'(gnt_idx);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i <= STAGES; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i <= STAGES; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_x_q     <= '0;
         rsp_y_q     <= '0;
      end else begin
         rsp_valid_q <= tag_q[STAGES].valid;
         if (tag_q[STAGES].valid) begin
            rsp_id_q <= tag_q[STAGES].id[IDW-1:0];
            rsp_x_q  <= cordic_x_out;
            rsp_y_q  <= cordic_y_out;
         end
      end
   end

   // Retire on the edge that raises rsp_valid, so the count peaks at STAGES+1.
   always_comb begin
      in_flight_d = in_flight_q;
      case ({xfer, tag_q[STAGES].valid})
         2'b10:   in_flight_d = in_flight_q + CNTW'(1);
         2'b01:   in_flight_d = in_flight_q - CNTW'(1);
         default: in_flight_d = in_flight_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) in_flight_q <= '0;
      else          in_flight_q <= in_flight_d;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_x     = rsp_x_q;
   assign rsp_y     = rsp_y_q;
   assign idle      = (in_flight_q == '0) && !xfer;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a behavioural CORDIC pipeline model.
module tb_cordic_arbiter;
   import cordic_pkg::*;

   localparam int WIDTH  = 16;
   localparam int STAGES = 16;
   localparam int NREQ   = 4;
   localparam int ATAN [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128,
                                64, 32, 16, 8, 4, 2, 1, 0};

   logic                  clk;
   logic                  reset_n;
   logic [NREQ-1:0]       req_valid, req_ready;
   logic [NREQ*WIDTH-1:0] req_x, req_y, req_angle;
   logic                  drain, cordic_reset;
   logic [WIDTH-1:0]      cordic_x_in, cordic_y_in, cordic_angle_in;
   logic [WIDTH-1:0]      cordic_x_out, cordic_y_out;
   logic                  rsp_valid, idle;
   logic [1:0]            rsp_id;
   logic [WIDTH-1:0]      rsp_x, rsp_y;

   int n_tests = 0;
   int n_fail  = 0;
   logic [WIDTH-1:0] exp_q [$];

   cordic_arbiter #(.WIDTH(WIDTH), .STAGES(STAGES), .NREQ(NREQ)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_angle(req_angle), .drain(drain),
      .cordic_reset(cordic_reset), .cordic_x_in(cordic_x_in),
      .cordic_y_in(cordic_y_in), .cordic_angle_in(cordic_angle_in),
      .cordic_x_out(cordic_x_out), .cordic_y_out(cordic_y_out),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
      .idle(idle)
   );

   // ---------------- clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- external pipeline model (STAGES+1 registers)
   function automatic logic [31:0] cordic_model(input logic signed [15:0] x0,
                                                input logic signed [15:0] y0,
                                                input logic signed [15:0] z0);
      int x, y, z, xn;
      x = int'(x0) <<< 8;
      y = int'(y0) <<< 8;
      z = int'(z0);
      for (int i = 0; i < 16; i++) begin
         if (z >= 0) begin
            xn = x - (y >>> i); y = y + (x >>> i); z = z - ATAN[i];
         end else begin
            xn = x + (y >>> i); y = y - (x >>> i); z = z + ATAN[i];
         end
         x = xn;
      end
      x = (x + 128) >>> 8;
      y = (y + 128) >>> 8;
      return {x[15:0], y[15:0]};
   endfunction

   logic [31:0] pipe [STAGES+1];
   always @(posedge clk or posedge cordic_reset) begin
      if (cordic_reset) begin
         for (int i = 0; i <= STAGES; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= cordic_model(cordic_x_in, cordic_y_in, cordic_angle_in);
         for (int i = 1; i <= STAGES; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign cordic_x_out = pipe[STAGES][31:16];
   assign cordic_y_out = pipe[STAGES][15:0];

   // ---------------- driver tasks
   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int tol(input logic [15:0] v, input int exp);
      int s;
      s = int'($signed(v));
      return (s - exp <= 8 && exp - s <= 8) ? exp : s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int k, input int x, input int y, input int a);
      req_x[k*WIDTH +: WIDTH]     = WIDTH'(x);
      req_y[k*WIDTH +: WIDTH]     = WIDTH'(y);
      req_angle[k*WIDTH +: WIDTH] = WIDTH'(a);
   endtask

   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (rsp_valid) begin
            lat = n;
            return;
         end
      end
   endtask

   // ---------------- stimulus and scoreboard
   initial begin
      int lat, pulses, bad, max_if, idle_after, prev;
      logic [31:0] em;

      reset_n = 1'b0; drain = 1'b0; req_valid = 4'b1111;
      for (int k = 0; k < NREQ; k++) set_req(k, 100 + k, 7, 0);
      repeat (2) step();
      check("rst_ready", int'(req_ready), 0);
      check("rst_idle", int'(idle), 1);
      check("rst_cordic_reset", int'(cordic_reset), 1);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_id", int'(rsp_id), 0);
      check("rst_rsp_x", int'(rsp_x), 0);
      check("rst_rsp_y", int'(rsp_y), 0);
      check("rst_cordic_x_in", int'(cordic_x_in), 0);

      req_valid = '0; reset_n = 1'b1; settle();
      check("post_rst_cordic_reset", int'(cordic_reset), 0);
      check("post_rst_idle", int'(idle), 1);

      // Single request from requester 2
      set_req(2, 9949, 0, 0); req_valid = 4'b0100; settle();
      check("single_ready", int'(req_ready), 4);
      check("single_x_in", int'(cordic_x_in), 9949);
      check("single_idle_busy", int'(idle), 0);
      step(); req_valid = '0; settle();
      check("noxfer_x_in_zero", int'(cordic_x_in), 0);
      wait_rsp(lat);
      check("single_latency", lat, 17);
      check("single_id", int'(rsp_id), 2);
      check("single_rsp_x", tol(rsp_x, 16384), 16384);
      check("single_rsp_y", tol(rsp_y, 0), 0);
      em = cordic_model(16'sd9949, 16'sd0, 16'sd0);
      step();
      check("single_pulse_len", int'(rsp_valid), 0);
      check("single_x_hold", int'(rsp_x), int'(em[31:16]));
      check("single_idle_after", int'(idle), 1);

      // Rotation by pi/4 from requester 0 (pointer sits at 3)
      set_req(0, 9949, 0, int'(PI_4)); req_valid = 4'b0001; settle();
      check("rot_ready", int'(req_ready), 1);
      step(); req_valid = '0;
      wait_rsp(lat);
      check("rot_latency", lat, 17);
      check("rot_id", int'(rsp_id), 0);
      check("rot_rsp_x", tol(rsp_x, 11585), 11585);
      check("rot_rsp_y", tol(rsp_y, 11585), 11585);

      // Pointer now 1: search order 1,2,3,0; no edge taken so pointer holds
      req_valid = 4'b1111; settle();
      check("rr_start_ptr", int'(req_ready), 2);
      req_valid = 4'b1101; settle();
      check("rr_skip_invalid", int'(req_ready), 4);
      drain = 1'b1; settle();
      check("drain_blocks_ready", int'(req_ready), 0);
      check("drain_x_in_zero", int'(cordic_x_in), 0);
      req_valid = '0; drain = 1'b0;
      step();

      // Reset pulse returns the pointer to 0, then 4-way contention
      reset_n = 1'b0; step(); reset_n = 1'b1;
      for (int k = 0; k < NREQ; k++) set_req(k, 1000 * (k + 1), 0, 0);
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         settle();
         check($sformatf("cont_ready_%0d", i), int'(req_ready), 1 << (i % 4));
         check($sformatf("cont_x_in_%0d", i), int'(cordic_x_in), 1000 * (i % 4 + 1));
         exp_q.push_back(WIDTH'(i % 4));
         step();
      end
      req_valid = '0;
      wait_rsp(lat);
      check("cont_first_latency", lat, 10);
      for (int j = 0; j < 8; j++) begin
         int id;
         if (j > 0) step();
         id = int'(exp_q.pop_front());
         em = cordic_model(16'(1000 * (id + 1)), 16'sd0, 16'sd0);
         check($sformatf("cont_valid_%0d", j), int'(rsp_valid), 1);
         check($sformatf("cont_id_%0d", j), int'(rsp_id), id);
         check($sformatf("cont_x_%0d", j), int'(rsp_x), int'(em[31:16]));
      end
      step();
      check("cont_done", int'(rsp_valid), 0);

      // Continuous traffic from requester 1: counter saturation
      set_req(1, 500, 0, 0); req_valid = 4'b0010;
      bad = 0; max_if = 0; pulses = 0;
      for (int i = 0; i < 40; i++) begin
         settle();
         if (req_ready !== 4'b0010) bad++;
         step();
         if (int'(dut.in_flight_q) > max_if) max_if = int'(dut.in_flight_q);
         if (rsp_valid) pulses++;
      end
      req_valid = '0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (rsp_valid) pulses++;
      end
      check("sat_ready_every_cycle", bad, 0);
      check("sat_in_flight_max", max_if, 17);
      check("sat_pulses", pulses, 40);
      check("sat_in_flight_end", int'(dut.in_flight_q), 0);
      check("sat_idle_end", int'(idle), 1);

      // Drain after 5 transfers; pointer is 2 so ids run 2,3,0,1,2
      req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(WIDTH'((i + 2) % 4));
         step();
      end
      drain = 1'b1;
      bad = 0; pulses = 0; idle_after = -1; prev = 0;
      for (int i = 0; i < 30; i++) begin
         settle();
         if (req_ready !== 4'b0000) bad++;
         step();
         if (rsp_valid) begin
            pulses++;
            check($sformatf("drain_id_%0d", pulses), int'(rsp_id),
                  exp_q.size() > 0 ? int'(exp_q.pop_front()) : -1);
         end
         if (prev == 1 && !rsp_valid) idle_after = int'(idle);
         prev = int'(rsp_valid);
      end
      check("drain_ready_low", bad, 0);
      check("drain_pulses", pulses, 5);
      check("drain_idle_after_last", idle_after, 1);
      drain = 1'b0; req_valid = '0;

      // Reset with 10 transfers in flight
      set_req(0, 321, 0, 0); req_valid = 4'b0001;
      repeat (10) step();
      req_valid = '0; reset_n = 1'b0;
      step(); step();
      reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (rsp_valid) pulses++;
      end
      check("midrst_no_rsp", pulses, 0);
      check("midrst_in_flight", int'(dut.in_flight_q), 0);
      check("midrst_idle", int'(idle), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "time limit");
   end

endmodule
